// File: rtl/recon_capture_ram.sv
// Capture RAM and checker for the DWT/IDWT loop output. It compares xs against a delay-aligned x_ref
// and keeps mismatch statistics. Define CAPTURE_WRAP_EN to turn the capture into a continuous ring buffer.
module recon_capture_ram #(
  parameter int W       = 16,
  parameter int DEPTH   = 1000,
  parameter int AW      = 10,
  parameter int LATENCY = 8,
  parameter int TOL     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x_ref,
  input  logic [W-1:0]  xs,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   err_count,
  output logic [W:0]    max_err,
  output logic [AW-1:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

  localparam state_t        RUN_ENTRY = (LATENCY == 0) ? CAPTURE : SKIP;
  localparam logic [5:0]    SKIP_LAST = 6'(LATENCY - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [W:0]    TOL_V     = (W+1)'(TOL);

  state_t        state;
  logic [5:0]    skip_cnt;
  logic [W-1:0]  x_ref_d;
  logic [W:0]    diff, absd;
  logic          mismatch, cap_we;

  // x_ref delay line, running in every state so alignment is ready when a run starts
  generate
    if (LATENCY == 0) begin : g_nodly
      assign x_ref_d = x_ref;
    end else begin : g_dly
      logic [LATENCY-1:0][W-1:0] dly;
      always_ff @(posedge clk) begin
        if (rst) dly <= '0;
        else begin
          dly[0] <= x_ref;
          for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign x_ref_d = dly[LATENCY-1];
    end
  endgenerate

  // Sign-extended to W+1 bits, so neither the difference nor its magnitude can overflow
  assign diff     = {xs[W-1], xs} - {x_ref_d[W-1], x_ref_d};
  assign absd     = diff[W] ? -diff : diff;
  assign mismatch = absd > TOL_V;
  assign cap_we   = (state == CAPTURE) && !start && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      skip_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_addr        <= '0;
      err_count      <= '0;
      max_err        <= '0;
      first_err_addr <= '0;
    end else if (start) begin
      state          <= RUN_ENTRY;
      skip_cnt       <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      wr_addr        <= '0;
      err_count      <= '0;
      max_err        <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        SKIP: begin
          if (skip_cnt == SKIP_LAST) state <= CAPTURE;
          else skip_cnt <= skip_cnt + 6'd1;
        end
        CAPTURE: begin
          if (mismatch) begin
            if (err_count == 16'h0000) first_err_addr <= wr_addr;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end
          if (absd > max_err) max_err <= absd;
          if (wr_addr == LAST_ADDR) begin
`ifdef CAPTURE_WRAP_EN
            wr_addr <= '0;
            done    <= 1'b1;
`else
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cap_we) mem[wr_addr] <= xs;
  end

  // Read-first: a same-cycle write to rd_addr is not visible until the next read
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_recon_capture_ram.sv
// Bench for recon_capture_ram. A cycle-position model is checked against the DUT on every cycle,
// and directed literal checks pin that model. A second LATENCY=0 instance covers the no-skip path.
module tb_recon_capture_ram;
  localparam int L = 8, D = 1000, TOL = 2;
`ifdef CAPTURE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] x_ref = '0, xs = '0;
  logic [9:0]  rd_addr = '0;
  logic [15:0] rd_data, err_count;
  logic        busy, done;
  logic [9:0]  wr_addr, first_err_addr;
  logic [16:0] max_err;

  logic        start0 = 1'b0;
  logic [15:0] x0 = '0, xs0 = '0;
  logic [3:0]  rd0 = '0;
  logic [15:0] rd_data0, err0;
  logic        busy0, done0;
  logic [3:0]  wr0, first0;
  logic [16:0] max0;

  always #5 clk = ~clk;

  recon_capture_ram #(.W(16), .DEPTH(D), .AW(10), .LATENCY(L), .TOL(TOL)) dut (
    .clk(clk), .rst(rst), .start(start), .x_ref(x_ref), .xs(xs), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .wr_addr(wr_addr), .err_count(err_count),
    .max_err(max_err), .first_err_addr(first_err_addr));

  recon_capture_ram #(.W(16), .DEPTH(16), .AW(4), .LATENCY(0), .TOL(TOL)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .x_ref(x0), .xs(xs0), .rd_addr(rd0),
    .rd_data(rd_data0), .busy(busy0), .done(done0), .wr_addr(wr0), .err_count(err0),
    .max_err(max0), .first_err_addr(first0));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] xh [20000];
  int dcyc = 0, g_off = 0, g_bad = -1;

  function automatic logic [15:0] pat(input int c);
    return 16'((c * 37) % 2001 - 1000);
  endfunction

  // xs is x_ref delayed by L plus an offset, with an optional single full-scale corruption
  task automatic drive();
    logic [15:0] xr;
    xr = (dcyc == g_bad - 8) ? 16'h7FFF : pat(dcyc);
    xh[dcyc] = xr;
    x_ref = xr;
    if (dcyc == g_bad)  xs = 16'h8000;
    else if (dcyc >= 8) xs = xh[dcyc-8] + 16'(g_off);
    else                xs = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      dcyc++;
      drive();
    end
  endtask

  task automatic run_start(output int s);
    start = 1'b1;
    s = dcyc;
    tick(1);
    start = 1'b0;
  endtask

  // ---------------- model ----------------
  int          m_cyc = 0, m_run = 0;
  bit          m_act = 1'b0, m_en = 1'b0;
  logic [15:0] m_mem [D];
  bit          m_vld [D];
  logic [15:0] m_dq [$];
  int          e_err = 0, e_max = 0, e_first = 0, e_busy = 0, e_done = 0, e_wa = 0;
  logic [15:0] e_rd = '0;
  bit          e_rdv = 1'b0;

  // Outputs follow from the position of each cycle relative to the last start
  always @(posedge clk) begin
    int pos, k, ad;
    logic [15:0] xd;
    if (rst) begin
      m_act = 1'b0; e_err = 0; e_max = 0; e_first = 0;
      e_rd = '0; e_rdv = 1'b1;
      m_dq.delete();
      repeat (L) m_dq.push_back(16'h0);
    end else begin
      xd = (L == 0) ? x_ref : m_dq[0];
      e_rd = m_mem[rd_addr];
      e_rdv = m_vld[rd_addr];
      if (start) begin
        m_act = 1'b1; m_run = m_cyc; e_err = 0; e_max = 0; e_first = 0;
      end else if (m_act) begin
        pos = m_cyc - m_run - 1 - L;
        if (pos >= 0 && (WRAP || pos < D)) begin
          m_mem[pos % D] = xs;
          m_vld[pos % D] = 1'b1;
          ad = int'($signed(xs)) - int'($signed(xd));
          if (ad < 0) ad = -ad;
          if (ad > TOL) begin
            if (e_err == 0) e_first = pos % D;
            if (e_err < 65535) e_err++;
          end
          if (ad > e_max) e_max = ad;
        end
      end
      if (L > 0) begin
        m_dq.push_back(x_ref);
        void'(m_dq.pop_front());
      end
    end
    k = m_cyc - m_run - L;
    e_busy = int'(m_act && (WRAP || k < D));
    e_done = int'(m_act && k >= D);
    if (!m_act || k < 0) e_wa = 0;
    else if (WRAP)       e_wa = k % D;
    else                 e_wa = (k < D) ? k : D - 1;
    m_cyc++;
    m_en = 1'b1;
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("wr_addr", 32'(wr_addr), 32'(e_wa));
      chk("err_count", 32'(err_count), 32'(e_err));
      chk("max_err", 32'(max_err), 32'(e_max));
      chk("first_err_addr", 32'(first_err_addr), 32'(e_first));
      if (e_rdv) chk("rd_data", {16'h0, rd_data}, {16'h0, e_rd});
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    drive();
    tick(1);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst err_count", 32'(err_count), 0);
    chk("rst max_err", 32'(max_err), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    tick(1);
    rst = 1'b0;

    // clean run
    run_start(s);
    chk("t1 busy after start", 32'(busy), 1);
    tick(L + D);
    chk("t1 done", 32'(done), 1);
    chk("t1 err_count", 32'(err_count), 0);
    chk("t1 max_err", 32'(max_err), 0);
`ifndef CAPTURE_WRAP_EN
    chk("t1 wr_addr hold", 32'(wr_addr), 999);
    chk("t1 busy", 32'(busy), 0);
    for (int k = 0; k < 1000; k += 333) begin
      rd_addr = 10'(k);
      tick(1);
      chk("t1 readback", {16'h0, rd_data}, {16'h0, xh[s+1+k]});
    end
`endif

    // offset at and beyond tolerance
    g_off = 2;
    run_start(s);
    tick(L + D);
    chk("t2 +2 err_count", 32'(err_count), 0);
    chk("t2 +2 max_err", 32'(max_err), 2);
    g_off = 3;
    run_start(s);
    tick(L + D);
    chk("t2 +3 err_count", 32'(err_count), 1000);
    chk("t2 +3 max_err", 32'(max_err), 3);
    chk("t2 +3 first_err", 32'(first_err_addr), 0);

    // single full-scale corruption at capture index 417
    g_off = 0;
    run_start(s);
    g_bad = s + 9 + 417;
    tick(L + D);
    chk("t3 err_count", 32'(err_count), 1);
    chk("t3 first_err", 32'(first_err_addr), 417);
    chk("t3 max_err", 32'(max_err), 65535);
    g_bad = -1;

    // restart mid-capture, then reset mid-capture
    g_off = 3;
    run_start(s);
    tick(L + 500);
    chk("t4 pre-restart err", 32'(err_count), 500);
    run_start(s);
    chk("t4 restart wr_addr", 32'(wr_addr), 0);
    chk("t4 restart err", 32'(err_count), 0);
    chk("t4 restart max", 32'(max_err), 0);
    chk("t4 restart done", 32'(done), 0);
    chk("t4 restart busy", 32'(busy), 1);
    g_off = 0;
    tick(L + D);
    chk("t4 done after restart", 32'(done), 1);
    run_start(s);
    tick(L + 300);
    rst = 1'b1;
    tick(1);
    chk("t4 rst busy", 32'(busy), 0);
    chk("t4 rst done", 32'(done), 0);
    chk("t4 rst wr_addr", 32'(wr_addr), 0);
    rst = 1'b0;
    tick(1);

    // LATENCY=0 instance: capture starts the cycle after start
    start0 = 1'b1; xs0 = 16'd55; x0 = 16'd55;
    tick(1);
    start0 = 1'b0;
    chk("t5 busy0", 32'(busy0), 1);
    chk("t5 wr0 start", 32'(wr0), 0);
    for (int i = 0; i < 16; i++) begin
      xs0 = 16'(100 + i);
      x0  = (i == 0) ? 16'd95 : xs0;
      tick(1);
      if (i == 0) chk("t5 wr0 first", 32'(wr0), 1);
    end
    chk("t5 done0", 32'(done0), 1);
    chk("t5 err0", 32'(err0), 1);
    chk("t5 max0", 32'(max0), 5);
    chk("t5 first0", 32'(first0), 0);
`ifndef CAPTURE_WRAP_EN
    chk("t5 wr0 hold", 32'(wr0), 15);
    chk("t5 busy0 end", 32'(busy0), 0);
`endif
    rd0 = 4'd0;
    tick(1);
    chk("t5 rd0 addr0", 32'(rd_data0), 100);
    rd0 = 4'd3;
    tick(1);
    chk("t5 rd0 addr3", 32'(rd_data0), 103);

`ifdef CAPTURE_WRAP_EN
    // ring buffer: 2500 samples leave the newest 1000 in place
    run_start(s);
    tick(L + 2500);
    chk("t6 wr_addr", 32'(wr_addr), 500);
    chk("t6 busy", 32'(busy), 1);
    chk("t6 done", 32'(done), 1);
    rd_addr = 10'd0;
    tick(1);
    chk("t6 ram0", {16'h0, rd_data}, {16'h0, xh[s+1+2000]});
    rd_addr = 10'd499;
    tick(1);
    chk("t6 ram499", {16'h0, rd_data}, {16'h0, xh[s+1+2499]});
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
